// File: rtl/s2p_pkg.sv
// ---------------------------------------------------------------------------
// s2p_pkg
// Shared definitions for the serial_to_parallel deserializer.
//   s2p_state_e  : assembly FSM state (IDLE = no bits held, SHIFT = partial word)
//   DEFAULT_WIDTH: default assembled word width
//   cnt_width()  : width of the bit counter for a given word width
// ---------------------------------------------------------------------------
package s2p_pkg;

    typedef enum logic {
        S2P_IDLE  = 1'b0,
        S2P_SHIFT = 1'b1
    } s2p_state_e;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage : s2p_pkg

// File: rtl/s2p_out_reg.sv
// ---------------------------------------------------------------------------
// s2p_out_reg
// One-entry valid/ready holding register for assembled words.
//
// Handshake: a transfer happens on a rising edge where valid_o && ready_i.
// data_o is stable while valid_o=1 and no transfer occurs. ready_i is ignored
// while valid_o=0. A load is accepted when the register is empty or is being
// drained on the same edge (no bubble); otherwise the load is dropped, the
// held word is kept, and drop_o flags it for that cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   load_i   in   a completed word is offered this cycle
//   data_i   in   offered word
//   ready_i  in   consumer accepts data_o this cycle
//   valid_o  out  data_o holds an unconsumed word (registered)
//   data_o   out  held word (registered)
//   drop_o   out  combinational: load_i && valid_o && !ready_i
// ---------------------------------------------------------------------------
module s2p_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             drop_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             accept_d;

    // Space exists if empty, or if the held word leaves on this very edge.
    assign accept_d = load_i && (!valid_q || ready_i);
    assign drop_o   = load_i && valid_q && !ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (accept_d) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : s2p_out_reg

// File: rtl/serial_to_parallel.sv
// ---------------------------------------------------------------------------
// serial_to_parallel
// Deserializer: collects LSB-first serial bits qualified by valid_i into
// WIDTH-bit words and presents them through a one-entry valid/ready register.
// Words completed while the output register is full and not draining are
// dropped and recorded in the sticky overrun flag.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   serial_i     in   serial data bit
//   valid_i      in   serial_i carries a valid bit this cycle
//   flush_i      in   discard partial word (priority over valid_i)
//   clear_i      in   clear sticky overrun (a same-edge overrun wins)
//   parallel_o   out  assembled word, bit 0 = first bit received
//   out_valid_o  out  parallel_o holds an unconsumed word
//   out_ready_i  in   consumer accepts parallel_o this cycle
//   bit_cnt_o    out  bits held in the current partial word
//   busy_o       out  partial word in progress (combinational from counter)
//   overrun_o    out  sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    s2p_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             overrun_q;

    logic             complete_d;
    logic [WIDTH-1:0] word_d;
    logic             drop_d;

    // The last bit goes straight into the offered word so the word is
    // available on the same edge that samples it.
    assign complete_d = valid_i && !flush_i && (state_q == S2P_SHIFT)
                        && (cnt_q == LAST_CNT);

    always_comb begin
        word_d            = shift_q;
        word_d[WIDTH-1]   = serial_i;
    end

    // Assembly FSM: IDLE holds no bits, SHIFT holds 1..WIDTH-1 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S2P_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (flush_i) begin
            state_q <= S2P_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (valid_i) begin
            case (state_q)
                S2P_IDLE: begin
                    state_q        <= S2P_SHIFT;
                    cnt_q          <= CNT_W'(1);
                    shift_q[cnt_q] <= serial_i;
                end
                S2P_SHIFT: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S2P_IDLE;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end else begin
                        cnt_q          <= cnt_q + CNT_W'(1);
                        shift_q[cnt_q] <= serial_i;
                    end
                end
                default: begin
                    state_q <= S2P_IDLE;
                    cnt_q   <= '0;
                    shift_q <= '0;
                end
            endcase
        end
    end

    s2p_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (complete_d),
        .data_i  (word_d),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (parallel_o),
        .drop_o  (drop_d)
    );

    // A new overrun beats clear_i on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (drop_d) begin
            overrun_q <= 1'b1;
        end else if (clear_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun_o = overrun_q;
    assign bit_cnt_o = cnt_q;
    assign busy_o    = (cnt_q != '0);

endmodule : serial_to_parallel

// File: tb/tb_serial_to_parallel.sv
// ---------------------------------------------------------------------------
// tb_serial_to_parallel
// Directed bench for serial_to_parallel with WIDTH=4. Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, so every
// check sees the result of the preceding edge.
// ---------------------------------------------------------------------------
module tb_serial_to_parallel;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic             serial_i;
    logic             valid_i;
    logic             flush_i;
    logic             clear_i;
    logic [WIDTH-1:0] parallel_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CNT_W-1:0] bit_cnt_o;
    logic             busy_o;
    logic             overrun_o;

    serial_to_parallel #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_i    (serial_i),
        .valid_i     (valid_i),
        .flush_i     (flush_i),
        .clear_i     (clear_i),
        .parallel_o  (parallel_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .bit_cnt_o   (bit_cnt_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_word(input string tag);
        logic [WIDTH-1:0] w;
        w = exp_q.pop_front();
        check(tag, 32'(parallel_o), 32'(w));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        valid_i  = 1'b1;
        serial_i = b;
        step();
        valid_i  = 1'b0;
        serial_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n     = 1'b0;
        serial_i    = 1'b0;
        valid_i     = 1'b0;
        flush_i     = 1'b0;
        clear_i     = 1'b0;
        out_ready_i = 1'b0;
        idle(2);
        check("rst_parallel", 32'(parallel_o), 0);
        check("rst_valid", 32'(out_valid_o), 0);
        check("rst_cnt", 32'(bit_cnt_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        reset_n = 1'b1;
        idle(1);

        // 1) back-to-back bits 1,0,1,1 -> 4'b1101 for exactly one cycle
        out_ready_i = 1'b1;
        exp_q.push_back(4'b1101);
        send_bit(1'b1);
        check("t1_cnt1", 32'(bit_cnt_o), 1);
        send_bit(1'b0);
        check("t1_cnt2", 32'(bit_cnt_o), 2);
        send_bit(1'b1);
        check("t1_cnt3", 32'(bit_cnt_o), 3);
        check("t1_valid_early", 32'(out_valid_o), 0);
        send_bit(1'b1);
        check("t1_valid", 32'(out_valid_o), 1);
        check_word("t1_word");
        check("t1_cnt0", 32'(bit_cnt_o), 0);
        step();
        check("t1_valid_one_cycle", 32'(out_valid_o), 0);

        // 2) bits 0,1,1,0 with three idle cycles between bits
        exp_q.push_back(4'b0110);
        send_bit(1'b0);
        idle(3);
        check("t2_cnt1", 32'(bit_cnt_o), 1);
        check("t2_busy1", 32'(busy_o), 1);
        send_bit(1'b1);
        idle(3);
        check("t2_cnt2", 32'(bit_cnt_o), 2);
        check("t2_busy2", 32'(busy_o), 1);
        send_bit(1'b1);
        idle(3);
        check("t2_cnt3", 32'(bit_cnt_o), 3);
        check("t2_busy3", 32'(busy_o), 1);
        send_bit(1'b0);
        check("t2_cnt0", 32'(bit_cnt_o), 0);
        check("t2_busy0", 32'(busy_o), 0);
        check("t2_valid", 32'(out_valid_o), 1);
        check_word("t2_word");
        step();

        // 3) back-pressure: 4'hA held, 4'h5 dropped, overrun sticky
        out_ready_i = 1'b0;
        exp_q.push_back(4'hA);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t3_valid_a", 32'(out_valid_o), 1);
        check_word("t3_word_a");
        check("t3_no_overrun", 32'(overrun_o), 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("t3_held_a", 32'(parallel_o), 32'hA);
        check("t3_overrun", 32'(overrun_o), 1);
        check("t3_valid_held", 32'(out_valid_o), 1);
        check("t3_cnt0", 32'(bit_cnt_o), 0);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("t3_drained", 32'(out_valid_o), 0);
        check("t3_overrun_sticky", 32'(overrun_o), 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t3_cleared", 32'(overrun_o), 0);

        // 3b) clear_i on the same edge as a new overrun: overrun wins
        exp_q.push_back(4'hF);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check_word("t3b_word_f");
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        clear_i = 1'b1;
        send_bit(1'b0);
        clear_i = 1'b0;
        check("t3b_overrun_wins", 32'(overrun_o), 1);
        check("t3b_held_f", 32'(parallel_o), 32'hF);
        clear_i     = 1'b1;
        out_ready_i = 1'b1;
        step();
        clear_i     = 1'b0;
        out_ready_i = 1'b0;
        check("t3b_cleared", 32'(overrun_o), 0);
        check("t3b_drained", 32'(out_valid_o), 0);

        // 4) continuous 8 bits; ready only on word-2 completion edge
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hC);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("t4_valid_w1", 32'(out_valid_o), 1);
        check_word("t4_word1");
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        out_ready_i = 1'b1;
        send_bit(1'b1);
        check("t4_valid_w2", 32'(out_valid_o), 1);
        check_word("t4_word2");
        check("t4_no_overrun", 32'(overrun_o), 0);
        step();
        check("t4_drained", 32'(out_valid_o), 0);

        // 5) flush beats a same-cycle valid bit; no stale bits afterwards
        send_bit(1'b1); send_bit(1'b1);
        check("t5_cnt2", 32'(bit_cnt_o), 2);
        flush_i  = 1'b1;
        valid_i  = 1'b1;
        serial_i = 1'b1;
        step();
        flush_i  = 1'b0;
        valid_i  = 1'b0;
        serial_i = 1'b0;
        check("t5_flush_cnt", 32'(bit_cnt_o), 0);
        check("t5_flush_busy", 32'(busy_o), 0);
        check("t5_flush_no_word", 32'(out_valid_o), 0);
        exp_q.push_back(4'b0111);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("t5_valid", 32'(out_valid_o), 1);
        check_word("t5_word");
        step();

        // 6) asynchronous reset mid-word with a held word
        out_ready_i = 1'b0;
        exp_q.push_back(4'h9);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check_word("t6_word_9");
        send_bit(1'b1); send_bit(1'b1);
        check("t6_cnt2", 32'(bit_cnt_o), 2);
        check("t6_valid_before", 32'(out_valid_o), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_parallel", 32'(parallel_o), 0);
        check("t6_async_valid", 32'(out_valid_o), 0);
        check("t6_async_cnt", 32'(bit_cnt_o), 0);
        check("t6_async_busy", 32'(busy_o), 0);
        check("t6_async_overrun", 32'(overrun_o), 0);
        step();
        reset_n     = 1'b1;
        out_ready_i = 1'b1;
        exp_q.push_back(4'hA);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t6_valid_after", 32'(out_valid_o), 1);
        check_word("t6_word_after");
        check("t6_cnt_after", 32'(bit_cnt_o), 0);
        step();
        check("t6_drained", 32'(out_valid_o), 0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_to_parallel

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Deserializer stage directly downstream of the parallel-to-serial shifter.
- Consumes a serial bit stream qualified by a valid strobe, LSB first, and assembles it into WIDTH-bit words.
- Presents each word on a one-entry valid/ready output register.
- Detects words lost to back-pressure and supports flushing a partial word.

Parameters:
- WIDTH, 4, bits per assembled word (≥2)
- CNT_W, $clog2(WIDTH), width of the bit counter (derived, not overridable)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- serial_i  input  1  serial data bit
- valid_i  input  1  serial_i carries a valid bit this cycle
- flush_i  input  1  discard the partially assembled word
- clear_i  input  1  clear the sticky overrun flag
- parallel_o  output  WIDTH  assembled word, LSB = first bit received
- out_valid_o  output  1  parallel_o holds an unconsumed word
- out_ready_i  input  1  consumer accepts parallel_o this cycle
- bit_cnt_o  output  CNT_W  bits collected in the current partial word
- busy_o  output  1  partial word in progress (bit_cnt_o != 0)
- overrun_o  output  1  sticky: a completed word was dropped

Behaviour:
- Reset is asynchronous on reset_n low. While reset is asserted:
  - parallel_o=0, out_valid_o=0, bit_cnt_o=0, busy_o=0, overrun_o=0
  - shift register cleared
- Reset mid-word discards the partial word and any held word. Operation resumes on the first clk edge after deassertion.
- Two-state assembly FSM:
  - IDLE: cnt==0. A valid_i bit moves the FSM to SHIFT.
  - SHIFT: cnt in 1..WIDTH-1. On the WIDTH-th valid bit, return to IDLE.
- Bit capture: on an edge with valid_i=1, serial_i is written to shift[cnt] and cnt increments. valid_i=0 holds all state; gaps between bits are allowed.
- Word completion: an edge with valid_i=1 and cnt==WIDTH-1 completes a word.
  - The word, including the current bit, is offered to the output register on that same edge.
  - cnt returns to 0.
  - Latency: out_valid_o rises in the cycle after the edge that sampled the last bit.
- Output register and handshake:
  - A transfer occurs on an edge where out_valid_o && out_ready_i.
  - parallel_o is stable while out_valid_o=1 and no transfer occurs.
  - out_ready_i is ignored while out_valid_o=0.
- Simultaneous completion and transfer on the same edge: the new word loads and out_valid_o stays 1. This is a full-throughput case with no bubble.
- Completion with no transfer (out_valid_o=1, out_ready_i=0):
  - The new word is dropped.
  - The held word is kept unchanged.
  - overrun_o sets to 1.
  - cnt still returns to 0.
- Completion with the output register empty: the word loads and out_valid_o goes to 1.
- Transfer with no completion: out_valid_o goes to 0. parallel_o retains its last value; it is don't-care for checking.
- flush_i:
  - Has priority over valid_i in the same cycle: cnt goes to 0, the shift register clears, and that cycle's bit is discarded.
  - Does not affect the output register or overrun_o.
- clear_i clears overrun_o. If clear_i and a new overrun occur on the same edge, the overrun wins (overrun_o=1).
- busy_o is combinational from cnt. All other outputs are registered.

Decomposition:
- Package s2p_pkg:
  - typedef of the FSM state enum {S2P_IDLE, S2P_SHIFT}
  - localparam DEFAULT_WIDTH=4
  - function cnt_width(int w) returning $clog2(w)
- Sub-module s2p_out_reg: the one-entry valid/ready holding register.
  - Inputs: load, data, ready.
  - Outputs: valid, data, drop (asserted when load && valid && !ready).
  - The top-level uses drop to set overrun_o.

Test Plan:
- Reset then four back-to-back valid bits 1,0,1,1 (WIDTH=4), out_ready_i=1 -> parallel_o=4'b1101 and out_valid_o=1 in the cycle after the 4th bit edge, and for exactly one cycle.
- Bits 0,1,1,0 with valid_i low for 3 cycles between each bit -> bit_cnt_o steps 1,2,3,0 and parallel_o=4'b0110. Between bits, busy_o=1 once any bit is held.
- Hold out_ready_i=0 and send two words 4'hA then 4'h5 -> parallel_o stays 4'hA, overrun_o=1 after the 8th bit edge. Raising out_ready_i for one cycle then gives out_valid_o=0. Then clear_i gives overrun_o=0.
- Continuous 8 bits with out_ready_i=1 in the completion cycle of word 2 -> out_valid_o stays 1 across the boundary, word 2 replaces word 1, overrun_o=0.
- Send 2 bits, then flush_i=1 with valid_i=1 the same cycle, then 4 bits 1,1,1,0 -> bit_cnt_o=0 after the flush, parallel_o=4'b0111, no stale bits.
- Assert reset_n=0 asynchronously mid-word (cnt=2) and with out_valid_o=1 -> all outputs 0 immediately, without waiting for clk. The next full 4-bit word assembles correctly.
